// File: rtl/muscle_ctx_scheduler.sv
// Time-multiplexes one shared muscle float datapath across N_CH channel contexts.
// Optional MUSCLE_FORCE_CLAMP_EN: negative integrated force is stored as +0.
module muscle_ctx_scheduler #(
  parameter int N_CH   = 4,
  parameter int CH_W   = 2,
  parameter int SETTLE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_tick,
  input  logic                 i_clr_overrun,
  input  logic [32*N_CH-1:0]   i_spike_cnt_flat,
  input  logic [32*N_CH-1:0]   i_pos_flat,
  input  logic [32*N_CH-1:0]   i_vel_flat,
  output logic [CH_W-1:0]      o_dp_ch,
  output logic [31:0]          o_dp_spike_cnt,
  output logic [31:0]          o_dp_pos,
  output logic [31:0]          o_dp_vel,
  output logic [31:0]          o_dp_spikes_i1,
  output logic [31:0]          o_dp_spikes_i2,
  output logic [31:0]          o_dp_h_i1,
  output logic [31:0]          o_dp_h_i2,
  output logic [31:0]          o_dp_T_i,
  input  logic [31:0]          i_dp_fp_spike,
  input  logic [31:0]          i_dp_h_i,
  input  logic [31:0]          i_dp_T_next,
  output logic [32*N_CH-1:0]   o_force_flat,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  logic [1:0]       r_state;
  logic [CH_W-1:0]  r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overrun;

  logic [31:0] r_spk [N_CH];
  logic [31:0] r_pos [N_CH];
  logic [31:0] r_vel [N_CH];
  logic [31:0] r_sp1 [N_CH];
  logic [31:0] r_sp2 [N_CH];
  logic [31:0] r_h1  [N_CH];
  logic [31:0] r_h2  [N_CH];
  logic [31:0] r_t   [N_CH];

  logic [31:0] w_t_wr;

  always_comb begin
    w_t_wr = i_dp_T_next;
`ifdef MUSCLE_FORCE_CLAMP_EN
    if (i_dp_T_next[31]) w_t_wr = 32'h0000_0000;
`else
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_cnt   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_spk[c] <= '0;
        r_pos[c] <= '0;
        r_vel[c] <= '0;
        r_sp1[c] <= '0;
        r_sp2[c] <= '0;
        r_h1[c]  <= '0;
        r_h2[c]  <= '0;
        r_t[c]   <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_tick) begin
            // Inputs are frozen for the whole sweep.
            for (int c = 0; c < N_CH; c++) begin
              r_spk[c] <= i_spike_cnt_flat[32*c +: 32];
              r_pos[c] <= i_pos_flat[32*c +: 32];
              r_vel[c] <= i_vel_flat[32*c +: 32];
            end
            r_ch    <= '0;
            r_cnt   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == CNT_LAST) r_state <= S_CAPTURE;
          else                   r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_CAPTURE: begin
          r_sp2[r_ch] <= r_sp1[r_ch];
          r_sp1[r_ch] <= i_dp_fp_spike;
          r_h2[r_ch]  <= r_h1[r_ch];
          r_h1[r_ch]  <= i_dp_h_i;
          r_t[r_ch]   <= w_t_wr;
          if (r_ch == CH_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_ch    <= r_ch + CH_W'(1);
            r_cnt   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A tick while busy is dropped but flagged; set beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_overrun <= 1'b0;
    else if (i_tick && r_state != S_IDLE) r_overrun <= 1'b1;
    else if (i_clr_overrun)                r_overrun <= 1'b0;
  end

  assign o_dp_ch        = r_ch;
  assign o_dp_spike_cnt = r_spk[r_ch];
  assign o_dp_pos       = r_pos[r_ch];
  assign o_dp_vel       = r_vel[r_ch];
  assign o_dp_spikes_i1 = r_sp1[r_ch];
  assign o_dp_spikes_i2 = r_sp2[r_ch];
  assign o_dp_h_i1      = r_h1[r_ch];
  assign o_dp_h_i2      = r_h2[r_ch];
  assign o_dp_T_i       = r_t[r_ch];

  for (genvar g = 0; g < N_CH; g++) begin : g_force
    assign o_force_flat[32*g +: 32] = r_t[g];
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_overrun = r_overrun;

endmodule
